// File: rtl/rst_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rst_sequencer_if : SoC-facing reset request / reset status bundle           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface rst_sequencer_if;
  logic       sw_rst_req;
  logic       wdt_kick;
  logic       soc_rst_n;
  logic       rst_done;
  logic [1:0] rst_cause;

  modport master (
    input  sw_rst_req,
    input  wdt_kick,
    output soc_rst_n,
    output rst_done,
    output rst_cause
  );

  modport slave (
    output sw_rst_req,
    output wdt_kick,
    input  soc_rst_n,
    input  rst_done,
    input  rst_cause
  );
endinterface
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rst_sequencer : PLL-lock qualified SoC reset sequencer with cause report    |
// | Optional watchdog reset enabled by macro RST_SEQ_WDT_EN                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rst_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 64,
  parameter int WDT_CYCLES         = 16777216
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  rst_sequencer_if.master   bus
);

  localparam int c_MAX_LH = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int c_MAX    = (c_MAX_LH > WDT_CYCLES) ? c_MAX_LH : WDT_CYCLES;
  localparam int c_CNT_W  = (c_MAX > 1) ? $clog2(c_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  localparam logic [1:0] c_CAUSE_POR  = 2'b00;
  localparam logic [1:0] c_CAUSE_LOCK = 2'b01;
  localparam logic [1:0] c_CAUSE_WDT  = 2'b10;
  localparam logic [1:0] c_CAUSE_SW   = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_rst_int_n;
  logic                   w_locked_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic [1:0]             r_cause;
  logic [1:0]             w_cause_nxt;
  logic                   r_soc_rst_n;
  logic                   r_rst_done;
  logic                   w_wdt_expire;

  // Both chains clear asynchronously with the board reset; release ripples through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync  <= '0;
      r_lock_sync <= '0;
    end else begin
      r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign w_rst_int_n = r_rst_sync[SYNC_STAGES-1];
  assign w_locked_s  = r_lock_sync[SYNC_STAGES-1];

`ifdef RST_SEQ_WDT_EN
  localparam logic [c_CNT_W-1:0] c_WDT_LAST = c_CNT_W'(WDT_CYCLES - 1);
  logic [c_CNT_W-1:0] r_wdt_cnt;

  always_ff @(posedge clk or negedge w_rst_int_n) begin
    if (!w_rst_int_n) begin
      r_wdt_cnt <= '0;
    end else if (r_state != ST_RUN || w_state_nxt != ST_RUN || bus.wdt_kick) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + c_CNT_ONE;
    end
  end

  assign w_wdt_expire = (r_state == ST_RUN) && !bus.wdt_kick && (r_wdt_cnt == c_WDT_LAST);
`else
  logic w_unused_kick;
  assign w_unused_kick = bus.wdt_kick;
  assign w_wdt_expire  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_LOCK_LAST) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_cause_nxt = c_CAUSE_LOCK;
        end else if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      ST_RUN: begin
        // Lock loss outranks watchdog, which outranks the software request
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_cause_nxt = c_CAUSE_LOCK;
        end else if (w_wdt_expire) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_cause_nxt = c_CAUSE_WDT;
        end else if (bus.sw_rst_req) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_cause_nxt = c_CAUSE_SW;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_int_n) begin
    if (!w_rst_int_n) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_cause     <= c_CAUSE_POR;
      r_soc_rst_n <= 1'b0;
      r_rst_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cause     <= w_cause_nxt;
      r_soc_rst_n <= (w_state_nxt == ST_RUN);
      r_rst_done  <= (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
    end
  end

  assign bus.soc_rst_n = r_soc_rst_n;
  assign bus.rst_done  = r_rst_done;
  assign bus.rst_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rst_sequencer : self-checking bench for rst_sequencer                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rst_sequencer;

  localparam int L = 8;
  localparam int H = 4;
  localparam int W = 32;
  localparam int S = 2;
  localparam int N = 4000;
`ifdef RST_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked = 1'b0;

  rst_sequencer_if bus_if();

  rst_sequencer #(
    .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .HOLD_CYCLES(H), .WDT_CYCLES(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic       l;
    logic       s;
    logic       k;
    logic [3:0] exp;
  } vec_t;

  // Reference model: release time stamps instead of states
  bit         m_wait;
  int         m_rel;
  int         m_hold_from;
  int         m_base;
  logic [1:0] m_cause;
  logic       p [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus_if.soc_rst_n, bus_if.rst_done, bus_if.rst_cause};
  endfunction

  task automatic step_drive(input logic l, input logic s, input logic k);
    @(posedge clk);
    #1;
    locked = l;
    bus_if.sw_rst_req = s;
    bus_if.wdt_kick = k;
    @(negedge clk);
  endtask

  task automatic start_hold(input int n, input logic [1:0] cause);
    m_rel       = n + 1 + H;
    m_hold_from = n + 1;
    m_base      = m_rel;
    m_cause     = cause;
  endtask

  task automatic model_step(input int n, input bit ls, input bit sw, input bit kick);
    if (m_wait) begin
      if (ls) begin
        m_wait      = 1'b0;
        m_rel       = n + 1 + L + H;
        m_hold_from = n + 1 + L;
        m_base      = m_rel;
      end
    end else if (n < m_rel) begin
      if (!ls) begin
        m_wait = 1'b1;
        if (n >= m_hold_from) m_cause = 2'b01;
      end
    end else begin
      if (!ls) begin
        m_wait  = 1'b1;
        m_cause = 2'b01;
      end else if (WDT_ON && !kick && (n - m_base == W - 1)) begin
        start_hold(n, 2'b10);
      end else if (sw) begin
        start_hold(n, 2'b11);
      end else if (kick) begin
        m_base = n + 1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [12];
    int         lows;
    int         dpre;
    int         first;
    int         highs;
    int         down;
    logic [3:0] got;
    logic [3:0] exp;
    logic       pt;
    logic       s;
    logic       k;
    logic       exp_soc;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'b1000};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'b0011};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'b0011};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'b0011};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'b0011};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'b1111};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'b1011};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b1011};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'b1011};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b1011};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 4'b0001};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0001};

    bus_if.sw_rst_req = 1'b0;
    bus_if.wdt_kick   = 1'b0;
    repeat (3) step_drive(1'b1, 1'b0, 1'b0);
    check("reset_outputs", outs(), 4'b0000);

    // Power-on release with lock already present
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    lows = 0;
    dpre = 0;
    while (bus_if.soc_rst_n !== 1'b1 && lows < 100) begin
      lows++;
      if (bus_if.rst_done === 1'b1) dpre++;
      step_drive(1'b1, 1'b0, 1'b0);
    end
    check("por_low_cycles", lows, 15);
    check("por_done_early", dpre, 0);
    check("por_release_outs", outs(), 4'b1100);
    step_drive(1'b1, 1'b0, 1'b0);
    check("por_done_single", outs(), 4'b1000);

    // Software reset, ignored request in HOLD, then lock loss from RUN
    for (int i = 0; i < 12; i++) begin
      step_drive(tbl[i].l, tbl[i].s, tbl[i].k);
      check($sformatf("table_row%0d", i), outs(), tbl[i].exp);
    end

    // One-cycle lock glitch during STABLE restarts the whole qualification
    first = -1;
    got = '0;
    for (int i = 0; i < 60 && first < 0; i++) begin
      step_drive((i == 5) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (bus_if.soc_rst_n === 1'b1) begin
        first = i;
        got = outs();
      end
    end
    check("glitch_release_cycle", first, 21);
    check("glitch_release_outs", got, 4'b1101);

    // Lock loss and software request in the same cycle
    step_drive(1'b0, 1'b0, 1'b1);
    step_drive(1'b0, 1'b0, 1'b1);
    step_drive(1'b0, 1'b1, 1'b1);
    check("simul_pre_outs", outs(), 4'b1001);
    step_drive(1'b0, 1'b0, 1'b0);
    check("simul_lock_wins", outs(), 4'b0001);
    highs = 0;
    repeat (6) begin
      step_drive(1'b0, 1'b0, 1'b0);
      if (bus_if.soc_rst_n !== 1'b0) highs++;
    end
    check("simul_stays_wait", highs, 0);

    // Re-lock follows the full sequence
    first = -1;
    for (int i = 0; i < 60 && first < 0; i++) begin
      step_drive(1'b1, 1'b0, 1'b1);
      if (bus_if.soc_rst_n === 1'b1) begin
        first = i;
        got = outs();
      end
    end
    check("relock_release_cycle", first, 15);
    check("relock_release_outs", got, 4'b1101);

    // Asynchronous board reset in the middle of HOLD
    step_drive(1'b1, 1'b1, 1'b1);
    step_drive(1'b1, 1'b0, 1'b1);
    check("sw_hold_entry", outs(), 4'b0011);
    step_drive(1'b1, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_in_hold", outs(), 4'b0000);
    repeat (3) step_drive(1'b1, 1'b0, 1'b0);

    // Watchdog: kicks every 20 cycles, then silence
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    lows = 0;
    while (bus_if.soc_rst_n !== 1'b1 && lows < 100) begin
      lows++;
      step_drive(1'b1, 1'b0, 1'b0);
    end
    check("wdt_por_low_cycles", lows, 15);
    first = -1;
    got = '0;
    for (int i = 0; i < 200; i++) begin
      step_drive(1'b1, 1'b0, (i <= 80 && i % 20 == 0));
      if (first < 0 && bus_if.soc_rst_n !== 1'b1) begin
        first = i;
        got = outs();
      end
    end
`ifdef RST_SEQ_WDT_EN
    check("wdt_expiry_cycle", first, 113);
    check("wdt_expiry_outs", got, 4'b0010);
`else
    check("no_wdt_reset", first, -1);
`endif

    // Randomized run against the reference model
    rst_n = 1'b0;
    repeat (3) step_drive(1'b1, 1'b0, 1'b0);
    m_wait      = 1'b1;
    m_cause     = 2'b00;
    m_rel       = 0;
    m_hold_from = 0;
    m_base      = 0;
    down        = 0;
    for (int t = 0; t < N; t++) begin
      if (down > 0) begin
        pt = 1'b0;
        down--;
      end else if ($urandom_range(0, 249) == 0) begin
        pt = 1'b0;
        down = $urandom_range(0, 15);
      end else begin
        pt = 1'b1;
      end
      p[t] = pt;
      s = ($urandom_range(0, 39) == 0);
      k = ($urandom_range(0, 24) == 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      locked = pt;
      bus_if.sw_rst_req = s;
      bus_if.wdt_kick = k;
      @(negedge clk);
      exp_soc = !m_wait && (t >= m_rel);
      exp = {exp_soc, exp_soc && (t == m_rel), m_cause};
      check($sformatf("random_t%0d", t), outs(), exp);
      if (t >= S) model_step(t, p[t-S], s, k);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
